mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have the following ports, clock and reset first:
  clk  in  1  single system clock; all state changes on its rising edge
  reset  in  1  asynchronous, active-high
  Instr  in  32  current instruction-register contents (fields: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12])
  ALUFlags  in  4  {N,Z,C,V} from the ALU, valid in the cycle produced
  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc  out  1 each  datapath/memory enables and selects
  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath mux selects
  ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
REQ-002 Mux encodings SHALL be:
  ALUSrcA: 00=A, 01=PC
  ALUSrcB: 00=register, 01=ExtImm, 10=constant 4
  ResultSrc: 00=ALUOut, 01=Data, 10=ALUResult
  AdrSrc: 0=PC, 1=Result

Function
REQ-003 Main FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-004 Transitions SHALL be:
  FETCH->DECODE
  DECODE-> MEMADR if Op=01; EXECUTEI if Op=00 and Funct[5]=1; EXECUTER if Op=00 and Funct[5]=0; BRANCH if Op=10; FETCH if Op=11
  MEMADR-> MEMRD if Funct[0]=1, else MEMWR
  MEMRD->MEMWB; MEMWB, MEMWR, BRANCH, ALUWB->FETCH
  EXECUTER/EXECUTEI-> FETCH if cmd=CMP, else ALUWB
REQ-005 State outputs SHALL be (unlisted signals 0, selects 00):
  FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, NextPC=1
  DECODE: ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10
  MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD
  MEMRD: ResultSrc=00, AdrSrc=1
  MEMWB: ResultSrc=01, RegW=1
  MEMWR: ResultSrc=00, AdrSrc=1, MemW=1
  EXECUTER: ALUSrcB=00, decoded ALUControl
  EXECUTEI: ALUSrcB=01, decoded ALUControl
  ALUWB: ResultSrc=00, RegW=1
  BRANCH: ALUSrcA=00, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, Branch=1
REQ-006 ALU decode from cmd=Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, no register write); any other cmd SHALL execute as ADD with writeback.
REQ-007 FlagW[1] (N,Z) SHALL be Funct[0] in EXECUTER/EXECUTEI; FlagW[0] (C,V) SHALL be Funct[0] only for ADD/SUB/CMP; CMP forces FlagW=11.
REQ-008 RegSrc[0] SHALL be 1 iff Op=10; RegSrc[1] SHALL be 1 iff Op=01 and Funct[0]=0; ImmSrc SHALL equal Op; all three combinational in every state.
REQ-009 CondEx SHALL be evaluated combinationally from Cond and the stored flags register per the 15 standard ARM codes (EQ..AL); Cond=1111 SHALL give CondEx=0.
REQ-010 CondEx SHALL be latched into cond_q on the DECODE->next edge and held until the next DECODE; cond_q alone SHALL gate the instruction.
REQ-011 The flags register SHALL load ALUFlags fields selected by FlagW at the end of EXECUTER/EXECUTEI only when cond_q=1; a flag update SHALL NOT affect the gating of the instruction that produced it.
REQ-012 Gated outputs SHALL be:
  RegWrite = RegW & cond_q
  MemWrite = MemW & cond_q
  PCWrite = NextPC | (PCS & cond_q), with PCS = Branch | (RegW & Rd=1111)
REQ-013 The BL link bit (Funct[4] for Op=10) SHALL be ignored; no link write occurs.

Reset
REQ-014 While reset=1, state SHALL be FETCH (asynchronously), flags=0000, cond_q=0; outputs SHALL show FETCH values (IRWrite=1, PCWrite=1, RegWrite=0, MemWrite=0).
REQ-015 Reset asserted in any state SHALL abandon the instruction with no further RegWrite/MemWrite; the first post-reset edge SHALL move FETCH->DECODE.

Verification
REQ-016 Reset; Instr=0xE0802001 (ADD R2,R0,R1) -> FETCH,DECODE,EXECUTER,ALUWB,FETCH; ALUControl=000 in EXECUTER; RegWrite=1 only in ALUWB; PCWrite=1 only in FETCH.
REQ-017 0xE5903004 (LDR) -> MEMADR (ALUSrcB=01), MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1); IRWrite=1 only in FETCH.
REQ-018 0xE5803004 (STR) -> RegSrc=10, MemWrite=1 only in MEMWR, RegWrite never 1.
REQ-019 0xE2500001 (SUBS) with ALUFlags=0100 in EXECUTEI -> Z latched; then 0x0A000002 (BEQ) -> PCWrite=1 in BRANCH; 0x1A000002 (BNE) -> PCWrite=0 in BRANCH.
REQ-020 Flags Z=0, 0x00802001 (ADDEQ) -> RegWrite=0 in ALUWB; 0xE080F001 (ADD PC) -> PCWrite=1 and RegWrite=1 in ALUWB.
REQ-021 Reset pulsed during MEMRD of an LDR -> immediate FETCH, flags=0000, no MEMWB RegWrite observed.

Source files
------------

// File: rtl/mc_control.sv
// Multicycle ARM-subset control unit: main FSM, ALU decode, condition check
// and flag register. Instructions are gated only by cond_q, which is captured
// when DECODE ends, so a flag write never affects the instruction that made it.
module mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl
);

  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRd    = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWr    = 4'd5;
  localparam logic [3:0] StExecuteR = 4'd6;
  localparam logic [3:0] StExecuteI = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBranch   = 4'd9;

  logic [3:0] state_q, state_d;
  logic [3:0] flags_q;
  logic       cond_q;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign cmd   = funct[4:1];
  assign rd    = Instr[15:12];

  // Bit 24 (BL link) and the operand fields are not used by this controller.
  logic unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  logic is_add, is_sub, is_cmp, is_execute;
  assign is_add     = (cmd == 4'b0100);
  assign is_sub     = (cmd == 4'b0010);
  assign is_cmp     = (cmd == 4'b1010);
  assign is_execute = (state_q == StExecuteR) || (state_q == StExecuteI);

  // ALU operation decode; unknown commands fall back to ADD.
  logic [2:0] alu_dec;
  always_comb begin
    unique case (cmd)
      4'b0100: alu_dec = 3'b000;
      4'b0010: alu_dec = 3'b001;
      4'b0000: alu_dec = 3'b010;
      4'b1100: alu_dec = 3'b011;
      4'b1010: alu_dec = 3'b001;
      default: alu_dec = 3'b000;
    endcase
  end

  // Flag write enables: {N,Z} on S-bit, {C,V} only for arithmetic ops.
  logic [1:0] flag_w;
  always_comb begin
    flag_w = 2'b00;
    if (is_execute) begin
      if (is_cmp) flag_w = 2'b11;
      else        flag_w = {funct[0], funct[0] & (is_add | is_sub)};
    end
  end

  // Condition evaluation against the stored flags.
  logic flag_n, flag_z, flag_c, flag_v, cond_ex;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  always_comb begin
    unique case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = StFetch;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        unique case (op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = funct[5] ? StExecuteI : StExecuteR;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd:    state_d = StMemWb;
      StExecuteR,
      StExecuteI: state_d = is_cmp ? StFetch : StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // Condition latch, captured as DECODE ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cond_q <= 1'b0;
    else if (state_q == StDecode) cond_q <= cond_ex;
  end

  // Flag register, written as an executed instruction's EXECUTE ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (is_execute && cond_q) begin
      if (flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  // Per-state datapath controls.
  logic regw, memw, branch, nextpc;
  always_comb begin
    regw       = 1'b0;
    memw       = 1'b0;
    branch     = 1'b0;
    nextpc     = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 3'b000;
    unique case (state_q)
      StFetch: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        nextpc    = 1'b1;
      end
      StDecode: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StMemAdr:   ALUSrcB = 2'b01;
      StMemRd:    AdrSrc  = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        regw      = 1'b1;
      end
      StMemWr: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      StExecuteR: ALUControl = alu_dec;
      StExecuteI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
      end
      StAluWb:    regw = ~is_cmp;
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Instruction-field decodes valid in every state, plus cond-gated enables.
  logic pcs;
  assign RegSrc   = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
  assign ImmSrc   = op;
  assign pcs      = branch | (regw & (rd == 4'b1111));
  assign RegWrite = regw & cond_q;
  assign MemWrite = memw & cond_q;
  assign PCWrite  = nextpc | (pcs & cond_q);

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: a vector table walks instructions state by
// state, then a hand sequence pulses reset mid-LDR and checks flag clearing.
module tb_mc_control;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;

  mc_control dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] IAdd   = 32'hE080_2001;
  localparam logic [31:0] ILdr   = 32'hE590_3004;
  localparam logic [31:0] IStr   = 32'hE580_3004;
  localparam logic [31:0] ISubs  = 32'hE250_0001;
  localparam logic [31:0] IBeq   = 32'h0A00_0002;
  localparam logic [31:0] IBne   = 32'h1A00_0002;
  localparam logic [31:0] ICmp   = 32'hE350_0000;
  localparam logic [31:0] IAddeq = 32'h0080_2001;
  localparam logic [31:0] IAddpc = 32'hE080_F001;
  localparam logic [31:0] IOp11  = 32'hEC00_0000;
  localparam logic [31:0] IBcs   = 32'h2A00_0002;
  localparam logic [3:0]  FNone  = 4'b1111;

  // Packed order: {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,
  //                ALUSrcB,ResultSrc,ImmSrc,ALUControl}
  function automatic logic [17:0] ex(input logic pcw, input logic mw, input logic rw,
                                     input logic irw, input logic adr, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] res, input logic [1:0] imm,
                                     input logic [2:0] ac);
    return {pcw, mw, rw, irw, adr, rs, sa, sb, res, imm, ac};
  endfunction

  function automatic logic [17:0] fetch_o(input logic [1:0] rs, input logic [1:0] imm);
    return ex(1, 0, 0, 1, 0, rs, 2'b01, 2'b10, 2'b10, imm, 3'b000);
  endfunction

  function automatic logic [17:0] decode_o(input logic [1:0] rs, input logic [1:0] imm);
    return ex(0, 0, 0, 0, 0, rs, 2'b01, 2'b10, 2'b10, imm, 3'b000);
  endfunction

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(input logic r, input logic [31:0] i, input logic [3:0] f,
                              input logic [17:0] e);
    vec_t v;
    v.rst = r; v.instr = i; v.flags = f; v.exp = e;
    return v;
  endfunction

  // Drive at the falling edge, sample 1 time unit later.
  task automatic step(input logic r, input logic [31:0] i, input logic [3:0] f,
                      input logic [17:0] e, input string name);
    logic [17:0] got;
    @(negedge clk);
    reset    = r;
    Instr    = i;
    ALUFlags = f;
    #1;
    got = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ImmSrc, ALUControl};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h (instr %08h)", name, got, e, i);
    end
  endtask

  initial begin
    reset    = 1'b1;
    Instr    = IAdd;
    ALUFlags = FNone;
    n_vec    = 0;
    n_bad    = 0;

    // ADD R2,R0,R1
    tbl.push_back(mk(1, IAdd, FNone, fetch_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, IAdd, FNone, fetch_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, IAdd, FNone, decode_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, IAdd, FNone, ex(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000)));
    tbl.push_back(mk(0, IAdd, FNone, ex(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000)));
    // LDR
    tbl.push_back(mk(0, ILdr, FNone, fetch_o(2'b00, 2'b01)));
    tbl.push_back(mk(0, ILdr, FNone, decode_o(2'b00, 2'b01)));
    tbl.push_back(mk(0, ILdr, FNone, ex(0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b01,3'b000)));
    tbl.push_back(mk(0, ILdr, FNone, ex(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b01,3'b000)));
    tbl.push_back(mk(0, ILdr, FNone, ex(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b01,2'b01,3'b000)));
    // STR
    tbl.push_back(mk(0, IStr, FNone, fetch_o(2'b10, 2'b01)));
    tbl.push_back(mk(0, IStr, FNone, decode_o(2'b10, 2'b01)));
    tbl.push_back(mk(0, IStr, FNone, ex(0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00,2'b01,3'b000)));
    tbl.push_back(mk(0, IStr, FNone, ex(0,1,0,0,1, 2'b10,2'b00,2'b00,2'b00,2'b01,3'b000)));
    // SUBS R0,R0,#1 with Z from the ALU
    tbl.push_back(mk(0, ISubs, FNone,   fetch_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, ISubs, FNone,   decode_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, ISubs, 4'b0100, ex(0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00,3'b001)));
    tbl.push_back(mk(0, ISubs, FNone,   ex(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000)));
    // BEQ taken, BNE not taken
    tbl.push_back(mk(0, IBeq, FNone, fetch_o(2'b01, 2'b10)));
    tbl.push_back(mk(0, IBeq, FNone, decode_o(2'b01, 2'b10)));
    tbl.push_back(mk(0, IBeq, FNone, ex(1,0,0,0,0, 2'b01,2'b00,2'b01,2'b10,2'b10,3'b000)));
    tbl.push_back(mk(0, IBne, FNone, fetch_o(2'b01, 2'b10)));
    tbl.push_back(mk(0, IBne, FNone, decode_o(2'b01, 2'b10)));
    tbl.push_back(mk(0, IBne, FNone, ex(0,0,0,0,0, 2'b01,2'b00,2'b01,2'b10,2'b10,3'b000)));
    // CMP R0,#0: flags become C=1, Z=0; returns straight to FETCH
    tbl.push_back(mk(0, ICmp, FNone,   fetch_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, ICmp, FNone,   decode_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, ICmp, 4'b0010, ex(0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00,3'b001)));
    // ADDEQ with Z=0: no write
    tbl.push_back(mk(0, IAddeq, FNone, fetch_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, IAddeq, FNone, decode_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, IAddeq, FNone, ex(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000)));
    tbl.push_back(mk(0, IAddeq, FNone, ex(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000)));
    // ADD PC,R0,R1: writeback also writes PC
    tbl.push_back(mk(0, IAddpc, FNone, fetch_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, IAddpc, FNone, decode_o(2'b00, 2'b00)));
    tbl.push_back(mk(0, IAddpc, FNone, ex(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000)));
    tbl.push_back(mk(0, IAddpc, FNone, ex(1,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,3'b000)));
    // Op=11: DECODE returns to FETCH
    tbl.push_back(mk(0, IOp11, FNone, fetch_o(2'b00, 2'b11)));
    tbl.push_back(mk(0, IOp11, FNone, decode_o(2'b00, 2'b11)));
    // BCS taken while C=1 from the CMP
    tbl.push_back(mk(0, IBcs, FNone, fetch_o(2'b01, 2'b10)));
    tbl.push_back(mk(0, IBcs, FNone, decode_o(2'b01, 2'b10)));
    tbl.push_back(mk(0, IBcs, FNone, ex(1,0,0,0,0, 2'b01,2'b00,2'b01,2'b10,2'b10,3'b000)));

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].instr, tbl[k].flags, tbl[k].exp, $sformatf("vec[%0d]", k));
    end

    // LDR abandoned by a reset pulse raised in the middle of MEMRD.
    step(0, ILdr, FNone, fetch_o(2'b00, 2'b01), "ldr_fetch");
    step(0, ILdr, FNone, decode_o(2'b00, 2'b01), "ldr_decode");
    step(0, ILdr, FNone, ex(0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b01,3'b000), "ldr_memadr");
    step(0, ILdr, FNone, ex(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b01,3'b000), "ldr_memrd");
    step(1, ILdr, FNone, fetch_o(2'b00, 2'b01), "rst_async_fetch");
    step(1, ILdr, FNone, fetch_o(2'b00, 2'b01), "rst_held_no_memwb");
    // After reset flags are clear, so BCS must not be taken.
    step(0, IBcs, FNone, fetch_o(2'b01, 2'b10), "post_rst_fetch");
    step(0, IBcs, FNone, decode_o(2'b01, 2'b10), "post_rst_decode");
    step(0, IBcs, FNone, ex(0,0,0,0,0, 2'b01,2'b00,2'b01,2'b10,2'b10,3'b000), "bcs_after_rst");
    step(0, IBcs, FNone, fetch_o(2'b01, 2'b10), "bcs_back_to_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
